fpu_seq: RTL



---
 rtl/fpu_seq_pkg.sv | 33 +++
 rtl/fpu_phase_gen.sv | 46 ++++
 rtl/fpu_seq.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/fpu_seq_pkg.sv
// Shared definitions for the F-PM microoperation sequencer.
// Holds the state encoding, the strobe phase numbering and the normalisation limit.
package fpu_seq_pkg;

  typedef enum logic [3:0] {
    IDLE,
    F1,
    F2,
    F4,
    F5,
    F6,
    F7,
    F8,
    F9,
    F10,
    F13,
    DONE
  } fpu_state_e;

  localparam logic [1:0] PH_STROB   = 2'd0;
  localparam logic [1:0] PH_STROBB  = 2'd1;
  localparam logic [1:0] PH_STROB2  = 2'd2;
  localparam logic [1:0] PH_STROB2B = 2'd3;

  localparam int NORM_MAX_DEF = 40;
  localparam int NORM_CNT_W   = 6;

  // F1 and DONE are the only states that do not run the four-phase strobe cycle.
  function automatic logic is_single(input fpu_state_e s);
    return (s == F1) || (s == DONE);
  endfunction

endpackage

// File: rtl/fpu_phase_gen.sv
// Four-phase strobe generator for the F-PM sequencer.
// Counts phases 0..3 in multi-cycle states and flags the cycle on which the state may change.
module fpu_phase_gen
  import fpu_seq_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_run,
  input  logic       i_single,
  output logic [1:0] o_phase,
  output logic       o_strob,
  output logic       o_strobb,
  output logic       o_strob2,
  output logic       o_strob2b,
  output logic       o_last_phase
);

  logic [1:0] r_phase;
  logic       w_multi;
  logic [3:0] w_strobe;

  assign w_multi = i_run & ~i_single;

  // The counter wraps 3 -> 0 exactly when the state register advances.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_phase <= PH_STROB;
    end else if (!w_multi) begin
      r_phase <= PH_STROB;
    end else begin
      r_phase <= r_phase + 2'd1;
    end
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_strobe
    assign w_strobe[gi] = w_multi & (r_phase == 2'(gi));
  end

  assign o_strob      = w_strobe[PH_STROB];
  assign o_strobb     = w_strobe[PH_STROBB];
  assign o_strob2     = w_strobe[PH_STROB2];
  assign o_strob2b    = w_strobe[PH_STROB2B];
  assign o_phase      = r_phase;
  assign o_last_phase = i_run & (i_single | (r_phase == PH_STROB2B));

endmodule

// File: rtl/fpu_seq.sv
// F-PM microoperation sequencer: walks states F1..F13 on each AWP start and drives
// the state lines, phase strobes and status flags back to CPU control.
module fpu_seq
  import fpu_seq_pkg::*;
#(
  parameter int NORM_MAX = NORM_MAX_DEF
) (
  input  logic clk_sys,
  input  logic clr_,
  input  logic start,
  input  logic af_sf,
  input  logic mw_mf,
  input  logic dw_df,
  input  logic ad_sd,
  input  logic g,
  input  logic fic_end,
  input  logic nz,
  input  logic ws,
  input  logic int_req,
  output logic f2,
  output logic f4,
  output logic f5,
  output logic f6,
  output logic f7,
  output logic f8,
  output logic f9,
  output logic f10,
  output logic f13,
  output logic strob_fp,
  output logic strobb_fp,
  output logic strob2_fp,
  output logic strob2b_fp,
  output logic clr_f,
  output logic clockm,
  output logic busy,
  output logic fp_done,
  output logic fp_int,
  output logic norm_ovf
);

  localparam logic [NORM_CNT_W-1:0] NORM_LIM = NORM_CNT_W'(NORM_MAX);

  fpu_state_e              r_state;
  logic [NORM_CNT_W-1:0]   r_norm_cnt;
  logic                    r_corr;
  logic                    r_fp_int;
  logic                    r_norm_ovf;

  fpu_state_e              w_state_next;
  logic [NORM_CNT_W-1:0]   w_norm_cnt_next;
  logic                    w_corr_next;
  logic                    w_fp_int_next;
  logic                    w_norm_ovf_next;

  logic                    w_run;
  logic                    w_single;
  logic                    w_last_phase;
  logic [1:0]              w_phase;
  logic                    w_unused_class;

  // mw_mf is the fall-through class: every branch that is not af/dw/ad takes it.
  assign w_unused_class = mw_mf;

  assign w_run    = (r_state != IDLE);
  assign w_single = is_single(r_state);

  fpu_phase_gen u_phase_gen (
    .i_clk        (clk_sys),
    .i_rst_n      (clr_),
    .i_run        (w_run),
    .i_single     (w_single),
    .o_phase      (w_phase),
    .o_strob      (strob_fp),
    .o_strobb     (strobb_fp),
    .o_strob2     (strob2_fp),
    .o_strob2b    (strob2b_fp),
    .o_last_phase (w_last_phase)
  );

  always_ff @(posedge clk_sys or negedge clr_) begin
    if (!clr_) begin
      r_state    <= IDLE;
      r_norm_cnt <= '0;
      r_corr     <= 1'b0;
      r_fp_int   <= 1'b0;
      r_norm_ovf <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_norm_cnt <= w_norm_cnt_next;
      r_corr     <= w_corr_next;
      r_fp_int   <= w_fp_int_next;
      r_norm_ovf <= w_norm_ovf_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_norm_cnt_next = r_norm_cnt;
    w_corr_next     = r_corr;
    w_fp_int_next   = r_fp_int;
    w_norm_ovf_next = r_norm_ovf;

    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_next    = F1;
          w_fp_int_next   = 1'b0;
          w_norm_ovf_next = 1'b0;
        end
      end
      F1: begin
        w_norm_cnt_next = '0;
        w_corr_next     = 1'b0;
        w_state_next    = F2;
      end
      DONE: begin
        w_state_next = IDLE;
      end
      default: begin
        // Branch inputs are only meaningful in the last strobe phase.
        if (w_last_phase) begin
          if (int_req) begin
            w_fp_int_next = 1'b1;
            w_state_next  = DONE;
          end else begin
            case (r_state)
              F2:  w_state_next = F4;
              F4:  w_state_next = af_sf ? F5 : F6;
              F5: begin
                if (g)            w_state_next = F13;
                else if (fic_end) w_state_next = F6;
                else              w_state_next = F8;
              end
              F6:  w_state_next = F7;
              F7: begin
                if (ad_sd)      w_state_next = DONE;
                else if (af_sf) w_state_next = F9;
                else            w_state_next = F8;
              end
              F8: begin
                if (fic_end) w_state_next = af_sf ? F6 : F9;
                else         w_state_next = af_sf ? F8 : F6;
              end
              F9: begin
                if (nz) begin
                  if (r_norm_cnt < NORM_LIM) begin
                    w_norm_cnt_next = r_norm_cnt + 1'b1;
                    w_state_next    = F9;
                  end else begin
                    w_norm_ovf_next = 1'b1;
                    w_state_next    = F13;
                  end
                end else begin
                  w_state_next = dw_df ? F10 : F13;
                end
              end
              F10: begin
                // Only one correction pass is allowed per operation.
                if (ws && !r_corr) begin
                  w_corr_next  = 1'b1;
                  w_state_next = F6;
                end else begin
                  w_state_next = F13;
                end
              end
              F13:     w_state_next = DONE;
              default: w_state_next = DONE;
            endcase
          end
        end
      end
    endcase
  end

  assign f2  = (r_state == F2);
  assign f4  = (r_state == F4);
  assign f5  = (r_state == F5);
  assign f6  = (r_state == F6);
  assign f7  = (r_state == F7);
  assign f8  = (r_state == F8);
  assign f9  = (r_state == F9);
  assign f10 = (r_state == F10);
  assign f13 = (r_state == F13);

  assign clr_f    = (r_state == F1);
  assign clockm   = ((r_state == F8) || (r_state == F9)) && (w_phase == PH_STROB2);
  assign busy     = w_run;
  assign fp_done  = (r_state == DONE);
  assign fp_int   = r_fp_int;
  assign norm_ovf = r_norm_ovf;

endmodule
